lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Memory-side responder for the load/store buffer and ROB.
- Accepts one-cycle load requests from the load buffer and level-held committed-store requests from the ROB, and sequences them over the byte-wide RAM port, one byte per cycle.
- Returns load results on the CDB-style mem_valid/mem_dependency/mem_value bus and drives mem_busy back to the load buffer.
- Serialises all memory traffic; at most one access is in flight.

Parameters:
ROB_ID_WIDTH, 3, width of ROB tags (matches ROB size width)
ADDR_WIDTH, 32, width of the byte address
IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the memory-mapped I/O window

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global ready; low freezes the block
lb2mem_ready  input  1  one-cycle load request strobe
lb2mem_load_type  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
lb2mem_addr  input  32  load byte address
lb2mem_dependency  input  ROB_ID_WIDTH  ROB tag of the load
rob2mem_store_valid  input  1  committed store pending; held until store_done
rob2mem_store_type  input  2  00 SB, 01 SH, 10 SW
rob2mem_addr  input  32  store byte address
rob2mem_value  input  32  store data
need_flush_in  input  1  pipeline flush
io_buffer_full  input  1  UART output buffer full
mem_din  input  8  RAM read data; valid one cycle after mem_a
mem_dout  output  8  RAM write data
mem_a  output  32  RAM address
mem_wr  output  1  RAM write enable
mem_valid  output  1  load result strobe
mem_dependency  output  ROB_ID_WIDTH  ROB tag of the result
mem_value  output  32  extended load result
mem_busy  output  1  combinational; do not issue a load
store_done  output  1  one-cycle store completion pulse

Behaviour:
- States: IDLE, LOAD, STORE. Byte count n = 1/2/4 from the type; byte counter is 3 bits.
- Reset (rst_in low, asynchronous): state IDLE; all outputs 0 (mem_a, mem_dout, mem_wr, mem_valid, mem_value, mem_dependency, store_done).
- rdy_in low: no state, counter or output register changes.
  - mem_wr is gated to 0 while rdy_in is low.
  - mem_a is held, so mem_din is valid again after resume.
- mem_busy = (state != IDLE) || (state == IDLE && lb2mem_ready).
  - This prevents back-to-back strobes from the buffer being lost.
- IDLE arbitration, evaluated at each edge:
  - A load strobe wins over a pending store.
  - A store is not accepted in the cycle in which store_done is high, because the ROB is still dropping its valid.
- LOAD accepted at edge E0:
  - mem_a <= addr, mem_wr <= 0.
  - At edge Ek (k = 1..n), capture mem_din into byte k-1; for k < n, mem_a <= addr + k (32-bit wrap).
  - At edge En: state IDLE, mem_valid <= 1 for exactly one cycle.
    - LB/LH sign-extend; LBU/LHU zero-extend.
    - mem_dependency carries the latched tag.
  - Latency: LB = 1 cycle, LW = 4 cycles from E0 to mem_valid high.
- STORE accepted at edge E0:
  - mem_a <= addr, mem_dout <= value[7:0], mem_wr <= 1.
  - Edges E1..E(n-1): mem_a <= addr + k, mem_dout <= value[8k+7:8k].
  - Edge En: mem_wr <= 0, store_done <= 1 for one cycle, state IDLE.
  - Bytes are little-endian.
- mem_valid and store_done are never high in the same cycle. Both clear at the edge after they assert.
- need_flush_in, sampled at an edge:
  - In LOAD: abort to IDLE with no mem_valid; mem_valid is also suppressed if the final edge coincides with the flush.
  - Any same-cycle lb2mem_ready is ignored.
  - STORE is never aborted (the store is committed); it finishes normally.
  - A store may be accepted on the same edge a flush is seen in IDLE.
- A load strobe arriving while not IDLE cannot occur, because mem_busy blocks it. If one arrives, it is dropped (checked by an assertion in simulation).
- Misaligned addresses are legal; bytes are simply sequential.

Optional Feature:
- Macro MEM_IO_GUARD_EN.
- When defined:
  - A store with addr[17:16] == IO_ADDR_HI is not accepted from IDLE while io_buffer_full is high; it is accepted on the first IDLE edge with io_buffer_full low.
  - A LOAD to the I/O window holds mem_busy high and is not started until io_buffer_full is low.
- When undefined: io_buffer_full is ignored (port present, unused); timing is as above.

Test Plan:
- LW at 0x100, RAM bytes 0x11,0x22,0x33,0x44, tag 5 -> mem_a sequence 0x100..0x103; mem_valid high 4 cycles after accept; mem_value 0x44332211, mem_dependency 5.
- LB then LBU at a byte 0x80 -> mem_value 0xFFFFFF80 then 0x00000080; LH of 0xFF7F -> 0xFFFFFF7F.
- SW addr 0x200, value 0xDEADBEEF held valid -> mem_wr 4 cycles with mem_dout EF,BE,AD,DE at 0x200..0x203; single store_done; no re-accept while done is high.
- Load strobe and store valid in the same IDLE cycle -> load runs first; the store starts on the edge after mem_valid; mem_busy high in the strobe cycle.
- need_flush_in during the 2nd byte of a LW -> no mem_valid, IDLE next cycle. Flush during an SH -> both bytes written, store_done asserted.
- rdy_in low for 3 cycles mid-LW -> outputs frozen, mem_wr 0; result identical to the unpaused run. With MEM_IO_GUARD_EN, SB to 0x30000 while io_buffer_full=1 for 5 cycles -> mem_wr first high 1 cycle after io_buffer_full drops.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundle between lsu_mem_ctrl, the load buffer, the ROB and the byte-wide RAM port.
interface lsu_mem_ctrl_if #(
  parameter int unsigned ROB_ID_WIDTH = 3,
  parameter int unsigned ADDR_WIDTH   = 32
);
  // load buffer request
  logic                    lb2mem_ready;
  logic [2:0]              lb2mem_load_type;
  logic [ADDR_WIDTH-1:0]   lb2mem_addr;
  logic [ROB_ID_WIDTH-1:0] lb2mem_dependency;
  // committed store from the ROB
  logic                    rob2mem_store_valid;
  logic [1:0]              rob2mem_store_type;
  logic [ADDR_WIDTH-1:0]   rob2mem_addr;
  logic [31:0]             rob2mem_value;
  // RAM port
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [ADDR_WIDTH-1:0]   mem_a;
  logic                    mem_wr;
  // results and flow control
  logic                    mem_valid;
  logic [ROB_ID_WIDTH-1:0] mem_dependency;
  logic [31:0]             mem_value;
  logic                    mem_busy;
  logic                    store_done;

  modport slave (
    input  lb2mem_ready, lb2mem_load_type, lb2mem_addr, lb2mem_dependency,
    input  rob2mem_store_valid, rob2mem_store_type, rob2mem_addr, rob2mem_value,
    input  mem_din,
    output mem_dout, mem_a, mem_wr,
    output mem_valid, mem_dependency, mem_value, mem_busy, store_done
  );

  modport master (
    output lb2mem_ready, lb2mem_load_type, lb2mem_addr, lb2mem_dependency,
    output rob2mem_store_valid, rob2mem_store_type, rob2mem_addr, rob2mem_value,
    output mem_din,
    input  mem_dout, mem_a, mem_wr,
    input  mem_valid, mem_dependency, mem_value, mem_busy, store_done
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Memory-side responder: serialises loads and committed stores over a byte-wide RAM port.
// Optional I/O back-pressure guard enabled by defining MEM_IO_GUARD_EN.
module lsu_mem_ctrl #(
  parameter int unsigned ROB_ID_WIDTH = 3,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter logic [1:0]  IO_ADDR_HI   = 2'b11
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           need_flush_in,
  input  logic           io_buffer_full,
  lsu_mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [2:0]              n_q, n_d;
  logic [2:0]              ltype_q, ltype_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [31:0]             sval_q, sval_d;
  logic [ROB_ID_WIDTH-1:0] tag_q, tag_d;
  logic [31:0]             buf_q, buf_d;
  logic [ADDR_WIDTH-1:0]   a_q, a_d;
  logic [7:0]              dout_q, dout_d;
  logic                    wr_q, wr_d;
  logic                    valid_q, valid_d;
  logic [31:0]             value_q, value_d;
  logic [ROB_ID_WIDTH-1:0] dep_q, dep_d;
  logic                    done_q, done_d;
  logic                    pend_q, pend_d;
  logic                    io_full;
  logic [31:0]             load_word;
  logic [2:0]              cnt_inc;

  // I/O back-pressure only matters when the guard is built in
`ifdef MEM_IO_GUARD_EN
  assign io_full = io_buffer_full;
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full;
  assign io_full        = 1'b0;
`endif

  // byte count for size field 00/01/10
  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

  // sign/zero extension according to load type
  function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] w);
    case (t)
      3'b000:  extend = {{24{w[7]}}, w[7:0]};
      3'b001:  extend = {{16{w[15]}}, w[15:0]};
      3'b100:  extend = {24'd0, w[7:0]};
      3'b101:  extend = {16'd0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  assign bus.mem_a          = a_q;
  assign bus.mem_dout       = dout_q;
  assign bus.mem_wr         = wr_q & rdy_in;
  assign bus.mem_valid      = valid_q;
  assign bus.mem_value      = value_q;
  assign bus.mem_dependency = dep_q;
  assign bus.store_done     = done_q;
  assign bus.mem_busy       = (state_q != IDLE) | bus.lb2mem_ready | pend_q;

  // next-state and output-register computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    ltype_d = ltype_q;
    base_d  = base_q;
    sval_d  = sval_q;
    tag_d   = tag_q;
    buf_d   = buf_q;
    a_d     = a_q;
    dout_d  = dout_q;
    wr_d    = wr_q;
    value_d = value_q;
    dep_d   = dep_q;
    pend_d  = pend_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    cnt_inc = 3'(cnt_q + 3'd1);
    load_word = buf_q;
    load_word[{cnt_q[1:0], 3'b000} +: 8] = bus.mem_din;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          if (need_flush_in) begin
            pend_d = 1'b0;
          end else if (!io_full) begin
            pend_d  = 1'b0;
            state_d = LOAD;
            cnt_d   = 3'd0;
            a_d     = base_q;
            wr_d    = 1'b0;
          end
        end else if (bus.lb2mem_ready && !need_flush_in) begin
          ltype_d = bus.lb2mem_load_type;
          n_d     = nbytes(bus.lb2mem_load_type[1:0]);
          base_d  = bus.lb2mem_addr;
          tag_d   = bus.lb2mem_dependency;
          cnt_d   = 3'd0;
          wr_d    = 1'b0;
          if (io_full && bus.lb2mem_addr[17:16] == IO_ADDR_HI) begin
            pend_d = 1'b1;
          end else begin
            state_d = LOAD;
            a_d     = bus.lb2mem_addr;
          end
        end else if (bus.rob2mem_store_valid && !done_q &&
                     !(io_full && bus.rob2mem_addr[17:16] == IO_ADDR_HI)) begin
          state_d = STORE;
          n_d     = nbytes(bus.rob2mem_store_type);
          base_d  = bus.rob2mem_addr;
          sval_d  = bus.rob2mem_value;
          cnt_d   = 3'd1;
          a_d     = bus.rob2mem_addr;
          dout_d  = bus.rob2mem_value[7:0];
          wr_d    = 1'b1;
        end
      end
      LOAD: begin
        if (need_flush_in) begin
          state_d = IDLE;
        end else begin
          buf_d = load_word;
          if (cnt_inc == n_q) begin
            state_d = IDLE;
            valid_d = 1'b1;
            value_d = extend(ltype_q, load_word);
            dep_d   = tag_q;
          end else begin
            cnt_d = cnt_inc;
            a_d   = base_q + ADDR_WIDTH'(cnt_inc);
          end
        end
      end
      STORE: begin
        if (cnt_q == n_q) begin
          state_d = IDLE;
          wr_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          a_d    = base_q + ADDR_WIDTH'(cnt_q);
          dout_d = sval_q[{cnt_q[1:0], 3'b000} +: 8];
          cnt_d  = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; frozen while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      n_q     <= 3'd0;
      ltype_q <= 3'd0;
      base_q  <= '0;
      sval_q  <= 32'd0;
      tag_q   <= '0;
      buf_q   <= 32'd0;
      a_q     <= '0;
      dout_q  <= 8'd0;
      wr_q    <= 1'b0;
      valid_q <= 1'b0;
      value_q <= 32'd0;
      dep_q   <= '0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else if (rdy_in) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      ltype_q <= ltype_d;
      base_q  <= base_d;
      sval_q  <= sval_d;
      tag_q   <= tag_d;
      buf_q   <= buf_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
      valid_q <= valid_d;
      value_q <= value_d;
      dep_q   <= dep_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  // load strobes are only legal while idle; a stray one is dropped
  a_no_strobe_when_busy: assert property (@(posedge clk_in) disable iff (!rst_in)
    (rdy_in && bus.lb2mem_ready) |-> (state_q == IDLE && !pend_q));

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a combinational byte RAM model.
module tb_lsu_mem_ctrl;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic need_flush_in = 1'b0;
  logic io_buffer_full = 1'b0;
  logic [7:0] ram [0:1023];
  int n_checks = 0;
  int n_fail = 0;

  lsu_mem_ctrl_if #(.ROB_ID_WIDTH(3), .ADDR_WIDTH(32)) bus ();

  lsu_mem_ctrl #(.ROB_ID_WIDTH(3), .ADDR_WIDTH(32), .IO_ADDR_HI(2'b11)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .need_flush_in (need_flush_in),
    .io_buffer_full(io_buffer_full),
    .bus           (bus)
  );

  always #5 clk_in = ~clk_in;

  assign bus.mem_din = ram[bus.mem_a[9:0]];

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  // strobe a load now, then follow mem_a per byte and check the result
  task automatic do_load(input string nm, input logic [2:0] t, input logic [31:0] addr,
                         input logic [2:0] tag, input int n, input logic [31:0] exp);
    bus.lb2mem_ready = 1'b1;
    bus.lb2mem_load_type = t;
    bus.lb2mem_addr = addr;
    bus.lb2mem_dependency = tag;
    #1;
    chk({nm, "_busy_strobe"}, 32'(bus.mem_busy), 32'd1);
    for (int k = 0; k < n; k++) begin
      tick();
      bus.lb2mem_ready = 1'b0;
      chk({nm, "_addr"}, bus.mem_a, addr + 32'(k));
      chk({nm, "_nowr"}, 32'(bus.mem_wr), 32'd0);
      chk({nm, "_novalid"}, 32'(bus.mem_valid), 32'd0);
    end
    tick();
    chk({nm, "_valid"}, 32'(bus.mem_valid), 32'd1);
    chk({nm, "_value"}, bus.mem_value, exp);
    chk({nm, "_dep"}, 32'(bus.mem_dependency), 32'(tag));
    chk({nm, "_idle"}, 32'(bus.mem_busy), 32'd0);
  endtask

  // hold a store valid through its done pulse and check each written byte
  task automatic do_store(input string nm, input logic [1:0] t, input logic [31:0] addr,
                          input logic [31:0] val, input int n);
    bus.rob2mem_store_valid = 1'b1;
    bus.rob2mem_store_type = t;
    bus.rob2mem_addr = addr;
    bus.rob2mem_value = val;
    for (int k = 0; k < n; k++) begin
      tick();
      chk({nm, "_wr"}, 32'(bus.mem_wr), 32'd1);
      chk({nm, "_addr"}, bus.mem_a, addr + 32'(k));
      chk({nm, "_dout"}, 32'(bus.mem_dout), 32'(val[8*k +: 8]));
      chk({nm, "_nodone"}, 32'(bus.store_done), 32'd0);
    end
    tick();
    chk({nm, "_wr_end"}, 32'(bus.mem_wr), 32'd0);
    chk({nm, "_done"}, 32'(bus.store_done), 32'd1);
    chk({nm, "_novalid"}, 32'(bus.mem_valid), 32'd0);
    tick();
    chk({nm, "_done_once"}, 32'(bus.store_done), 32'd0);
    chk({nm, "_no_reaccept"}, 32'(bus.mem_wr), 32'd0);
    chk({nm, "_idle"}, 32'(bus.mem_busy), 32'd0);
    bus.rob2mem_store_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
    ram[10'h104] = 8'h80; ram[10'h106] = 8'h7F; ram[10'h107] = 8'hFF;
    bus.lb2mem_ready = 1'b0;
    bus.lb2mem_load_type = 3'b000;
    bus.lb2mem_addr = 32'd0;
    bus.lb2mem_dependency = 3'd0;
    bus.rob2mem_store_valid = 1'b0;
    bus.rob2mem_store_type = 2'b00;
    bus.rob2mem_addr = 32'd0;
    bus.rob2mem_value = 32'd0;

    // reset state
    tick();
    chk("rst_a", bus.mem_a, 32'd0);
    chk("rst_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst_dout", 32'(bus.mem_dout), 32'd0);
    chk("rst_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_value", bus.mem_value, 32'd0);
    chk("rst_dep", 32'(bus.mem_dependency), 32'd0);
    chk("rst_done", 32'(bus.store_done), 32'd0);
    chk("rst_busy", 32'(bus.mem_busy), 32'd0);
    rst_in = 1'b1;
    tick();

    // word and sub-word loads with extension
    do_load("lw", 3'b010, 32'h100, 3'd5, 4, 32'h44332211);
    tick();
    chk("lw_valid_clear", 32'(bus.mem_valid), 32'd0);
    do_load("lb", 3'b000, 32'h104, 3'd1, 1, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h104, 3'd2, 1, 32'h00000080);
    do_load("lh", 3'b001, 32'h106, 3'd3, 2, 32'hFFFFFF7F);
    tick();

    // word store, little-endian bytes, single done
    do_store("sw", 2'b10, 32'h200, 32'hDEADBEEF, 4);

    // simultaneous load strobe and store: load first
    bus.lb2mem_ready = 1'b1;
    bus.lb2mem_load_type = 3'b000;
    bus.lb2mem_addr = 32'h104;
    bus.lb2mem_dependency = 3'd2;
    bus.rob2mem_store_valid = 1'b1;
    bus.rob2mem_store_type = 2'b00;
    bus.rob2mem_addr = 32'h210;
    bus.rob2mem_value = 32'h0000005A;
    #1;
    chk("arb_busy", 32'(bus.mem_busy), 32'd1);
    tick();
    bus.lb2mem_ready = 1'b0;
    chk("arb_load_addr", bus.mem_a, 32'h104);
    chk("arb_load_nowr", 32'(bus.mem_wr), 32'd0);
    tick();
    chk("arb_valid", 32'(bus.mem_valid), 32'd1);
    chk("arb_value", bus.mem_value, 32'hFFFFFF80);
    chk("arb_wr_wait", 32'(bus.mem_wr), 32'd0);
    tick();
    chk("arb_st_wr", 32'(bus.mem_wr), 32'd1);
    chk("arb_st_addr", bus.mem_a, 32'h210);
    chk("arb_st_dout", 32'(bus.mem_dout), 32'h5A);
    chk("arb_valid_clear", 32'(bus.mem_valid), 32'd0);
    tick();
    chk("arb_done", 32'(bus.store_done), 32'd1);
    chk("arb_wr_end", 32'(bus.mem_wr), 32'd0);
    bus.rob2mem_store_valid = 1'b0;
    tick();
    chk("arb_done_clear", 32'(bus.store_done), 32'd0);

    // flush during second byte of LW
    bus.lb2mem_ready = 1'b1;
    bus.lb2mem_load_type = 3'b010;
    bus.lb2mem_addr = 32'h100;
    bus.lb2mem_dependency = 3'd3;
    tick();
    bus.lb2mem_ready = 1'b0;
    tick();
    chk("fl_addr2", bus.mem_a, 32'h101);
    need_flush_in = 1'b1;
    tick();
    need_flush_in = 1'b0;
    chk("fl_novalid", 32'(bus.mem_valid), 32'd0);
    #1;
    chk("fl_idle", 32'(bus.mem_busy), 32'd0);
    tick();
    chk("fl_novalid2", 32'(bus.mem_valid), 32'd0);

    // flush during SH does not abort the store
    bus.rob2mem_store_valid = 1'b1;
    bus.rob2mem_store_type = 2'b01;
    bus.rob2mem_addr = 32'h220;
    bus.rob2mem_value = 32'h1234BEEF;
    tick();
    chk("flsh_wr0", 32'(bus.mem_wr), 32'd1);
    chk("flsh_dout0", 32'(bus.mem_dout), 32'hEF);
    need_flush_in = 1'b1;
    tick();
    chk("flsh_wr1", 32'(bus.mem_wr), 32'd1);
    chk("flsh_addr1", bus.mem_a, 32'h221);
    chk("flsh_dout1", 32'(bus.mem_dout), 32'hBE);
    tick();
    chk("flsh_done", 32'(bus.store_done), 32'd1);
    chk("flsh_wr_end", 32'(bus.mem_wr), 32'd0);
    need_flush_in = 1'b0;
    bus.rob2mem_store_valid = 1'b0;
    tick();

    // rdy_in low for 3 cycles mid-LW
    bus.lb2mem_ready = 1'b1;
    bus.lb2mem_load_type = 3'b010;
    bus.lb2mem_addr = 32'h100;
    bus.lb2mem_dependency = 3'd6;
    tick();
    bus.lb2mem_ready = 1'b0;
    tick();
    chk("rdy_addr_pre", bus.mem_a, 32'h101);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_hold_addr", bus.mem_a, 32'h101);
      chk("rdy_hold_wr", 32'(bus.mem_wr), 32'd0);
      chk("rdy_hold_valid", 32'(bus.mem_valid), 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    chk("rdy_addr2", bus.mem_a, 32'h102);
    tick();
    chk("rdy_addr3", bus.mem_a, 32'h103);
    tick();
    chk("rdy_valid", 32'(bus.mem_valid), 32'd1);
    chk("rdy_value", bus.mem_value, 32'h44332211);
    chk("rdy_dep", 32'(bus.mem_dependency), 32'd6);
    tick();

    // rdy_in low during a store gates mem_wr
    bus.rob2mem_store_valid = 1'b1;
    bus.rob2mem_store_type = 2'b00;
    bus.rob2mem_addr = 32'h230;
    bus.rob2mem_value = 32'h00000077;
    tick();
    chk("rdst_wr", 32'(bus.mem_wr), 32'd1);
    rdy_in = 1'b0;
    #1;
    chk("rdst_gated", 32'(bus.mem_wr), 32'd0);
    tick();
    chk("rdst_gated2", 32'(bus.mem_wr), 32'd0);
    chk("rdst_addr", bus.mem_a, 32'h230);
    chk("rdst_nodone", 32'(bus.store_done), 32'd0);
    rdy_in = 1'b1;
    #1;
    chk("rdst_resume", 32'(bus.mem_wr), 32'd1);
    chk("rdst_dout", 32'(bus.mem_dout), 32'h77);
    tick();
    chk("rdst_done", 32'(bus.store_done), 32'd1);
    bus.rob2mem_store_valid = 1'b0;
    tick();

    // store to the I/O window with the output buffer full
    io_buffer_full = 1'b1;
    bus.rob2mem_store_valid = 1'b1;
    bus.rob2mem_store_type = 2'b00;
    bus.rob2mem_addr = 32'h00030000;
    bus.rob2mem_value = 32'h00000041;
`ifdef MEM_IO_GUARD_EN
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("io_blocked", 32'(bus.mem_wr), 32'd0);
    end
    io_buffer_full = 1'b0;
    tick();
`else
    tick();
`endif
    chk("io_wr", 32'(bus.mem_wr), 32'd1);
    chk("io_addr", bus.mem_a, 32'h00030000);
    chk("io_dout", 32'(bus.mem_dout), 32'h41);
    tick();
    chk("io_done", 32'(bus.store_done), 32'd1);
    bus.rob2mem_store_valid = 1'b0;
    io_buffer_full = 1'b0;
    tick();
    chk("io_done_clear", 32'(bus.store_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
